// File: rtl/game_display_ctrl_pkg.sv
// Shared types and constants for the guessing-game display sequencer.
package game_disp_pkg;

  // Display mux select codes
  localparam logic [1:0] SEL_SCORE = 2'b00;
  localparam logic [1:0] SEL_INPUT = 2'b01;
  localparam logic [1:0] SEL_LAST  = 2'b10;
  localparam logic [1:0] SEL_RAND  = 2'b11;

  typedef enum logic [2:0] {IDLE, REVEAL, ENTRY, RESULT, GAME_OVER} state_t;

  // Timer width able to hold the largest of the three phase lengths.
  function automatic int unsigned timer_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  // Mux select for a given phase; peek only overrides the switch view in ENTRY.
  function automatic logic [1:0] sel_for(state_t s, logic peek);
    logic [1:0] sel;
    unique case (s)
      REVEAL:  sel = SEL_RAND;
      ENTRY:   sel = peek ? SEL_SCORE : SEL_INPUT;
      RESULT:  sel = SEL_LAST;
      default: sel = SEL_SCORE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/game_display_ctrl_if.sv
// Control/status bundle between the game sequencer and its environment.
interface game_display_ctrl_if;
  logic       start_pulse;
  logic       submit_pulse;
  logic       abort;
  logic       peek_score;
  logic       match;
  logic [1:0] sel;
  logic       new_rand;
  logic       capture_turn;
  logic       score_inc;
  logic       busy;
  logic [7:0] turn_count;
  logic       game_over;

  modport master (
    output start_pulse, submit_pulse, abort, peek_score, match,
    input  sel, new_rand, capture_turn, score_inc, busy, turn_count, game_over
  );

  modport slave (
    input  start_pulse, submit_pulse, abort, peek_score, match,
    output sel, new_rand, capture_turn, score_inc, busy, turn_count, game_over
  );
endinterface

// File: rtl/game_display_ctrl_hold_timer.sv
// Loadable down-counter that holds at zero; used to time each game phase.
module hold_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  // Load takes priority over counting; count stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o   = (count_q == '0);
  assign expire_o = zero_o && !load_i;

endmodule

// File: rtl/game_display_ctrl.sv
// Turn sequencer: walks each turn through reveal, entry and result phases and drives the
// display mux select plus the datapath latch/score strobes. All outputs are registered.
module game_display_ctrl
  import game_disp_pkg::*;
#(
  parameter int unsigned REVEAL_CYCLES = 100_000_000,
  parameter int unsigned RESULT_CYCLES = 200_000_000,
  parameter int unsigned ENTRY_TIMEOUT = 1_000_000_000,
  parameter int unsigned MAX_TURNS     = 10
) (
  input logic               clk,
  input logic               rst_n,
  game_display_ctrl_if.slave bus
);

  localparam int unsigned W = timer_width(REVEAL_CYCLES, RESULT_CYCLES, ENTRY_TIMEOUT);
  localparam logic [W-1:0] RevealLoad = W'(REVEAL_CYCLES - 1);
  localparam logic [W-1:0] EntryLoad  = W'(ENTRY_TIMEOUT - 1);
  localparam logic [W-1:0] ResultLoad = W'(RESULT_CYCLES - 1);
  localparam logic [7:0]   MaxTurns   = 8'(MAX_TURNS);

  state_t       state_q, state_d;
  logic [7:0]   turn_q, turn_d;
  logic [1:0]   sel_q, sel_d;
  logic         new_rand_q, new_rand_d;
  logic         capture_q, capture_d;
  logic         score_q, score_d;
  logic         busy_q, busy_d;
  logic         game_over_q, game_over_d;
  logic         tmr_load;
  logic [W-1:0] tmr_val;
  logic         tmr_zero;
  logic         tmr_expire;

  hold_timer #(
    .W (W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero),
    .expire_o   (tmr_expire)
  );

  // Next-state, timer control and strobe decode. REVEAL/ENTRY exits use the raw zero flag
  // because they reload the timer themselves; RESULT exit never loads, so expire is safe there.
  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    new_rand_d = 1'b0;
    capture_d  = 1'b0;
    score_d    = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    if (bus.abort) begin
      state_d  = IDLE;
      turn_d   = '0;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, GAME_OVER: begin
          if (bus.start_pulse) begin
            state_d    = REVEAL;
            new_rand_d = 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = RevealLoad;
            if (state_q == GAME_OVER) turn_d = '0;
          end
        end
        REVEAL: begin
          if (tmr_zero) begin
            state_d  = ENTRY;
            tmr_load = 1'b1;
            tmr_val  = EntryLoad;
          end
        end
        ENTRY: begin
          if (bus.submit_pulse || tmr_zero) begin
            state_d   = RESULT;
            capture_d = 1'b1;
            score_d   = bus.submit_pulse && bus.match;
            tmr_load  = 1'b1;
            tmr_val   = ResultLoad;
            turn_d    = (turn_q == 8'hff) ? turn_q : turn_q + 8'd1;
          end
        end
        RESULT: begin
          if (tmr_expire) state_d = (turn_q == MaxTurns) ? GAME_OVER : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    sel_d       = sel_for(state_d, bus.peek_score);
    busy_d      = state_d inside {REVEAL, ENTRY, RESULT};
    game_over_d = (state_d == GAME_OVER);
  end

  // State and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      turn_q      <= '0;
      sel_q       <= SEL_SCORE;
      new_rand_q  <= 1'b0;
      capture_q   <= 1'b0;
      score_q     <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      sel_q       <= sel_d;
      new_rand_q  <= new_rand_d;
      capture_q   <= capture_d;
      score_q     <= score_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.sel          = sel_q;
  assign bus.new_rand     = new_rand_q;
  assign bus.capture_turn = capture_q;
  assign bus.score_inc    = score_q;
  assign bus.busy         = busy_q;
  assign bus.turn_count   = turn_q;
  assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_game_display_ctrl.sv
// Bench for game_display_ctrl: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a phase/elapsed-cycle reference model.
module tb_game_display_ctrl;

  localparam int RV  = 4;
  localparam int RC  = 3;
  localparam int TO  = 10;
  localparam int MXT = 2;

  localparam int PH_IDLE = 0, PH_REVEAL = 1, PH_ENTRY = 2, PH_RESULT = 3, PH_OVER = 4;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  game_display_ctrl_if bus ();

  game_display_ctrl #(
    .REVEAL_CYCLES (RV),
    .RESULT_CYCLES (RC),
    .ENTRY_TIMEOUT (TO),
    .MAX_TURNS     (MXT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: current phase, cycles spent in it, turns, expected outputs.
  int         m_phase;
  int         m_elapsed;
  int         m_turns;
  logic [1:0] e_sel;
  logic       e_new_rand, e_capture, e_score;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = PH_IDLE; m_elapsed = 0; m_turns = 0;
      e_new_rand = 0; e_capture = 0; e_score = 0;
    end else begin
      e_new_rand = 0; e_capture = 0; e_score = 0;
      m_elapsed++;
      if (bus.abort) begin
        m_phase = PH_IDLE; m_turns = 0;
      end else if (m_phase == PH_IDLE || m_phase == PH_OVER) begin
        if (bus.start_pulse) begin
          if (m_phase == PH_OVER) m_turns = 0;
          m_phase = PH_REVEAL; m_elapsed = 0; e_new_rand = 1;
        end
      end else if (m_phase == PH_REVEAL) begin
        if (m_elapsed == RV) begin m_phase = PH_ENTRY; m_elapsed = 0; end
      end else if (m_phase == PH_ENTRY) begin
        if (bus.submit_pulse || m_elapsed == TO) begin
          e_capture = 1;
          e_score   = bus.submit_pulse && bus.match;
          if (m_turns < 255) m_turns++;
          m_phase = PH_RESULT; m_elapsed = 0;
        end
      end else if (m_elapsed == RC) begin
        m_phase = (m_turns == MXT) ? PH_OVER : PH_IDLE;
      end
    end
    case (m_phase)
      PH_REVEAL: e_sel = 2'b11;
      PH_ENTRY:  e_sel = (rst_n && bus.peek_score) ? 2'b00 : 2'b01;
      PH_RESULT: e_sel = 2'b10;
      default:   e_sel = 2'b00;
    endcase
  end

  // Every-cycle comparison, away from the active edge.
  always @(posedge clk) begin
    #1;
    check("sel", bus.sel, e_sel);
    check("new_rand", bus.new_rand, e_new_rand);
    check("capture_turn", bus.capture_turn, e_capture);
    check("score_inc", bus.score_inc, e_score);
    check("busy", bus.busy, (m_phase == PH_REVEAL || m_phase == PH_ENTRY ||
                             m_phase == PH_RESULT) ? 1 : 0);
    check("turn_count", bus.turn_count, m_turns);
    check("game_over", bus.game_over, (m_phase == PH_OVER) ? 1 : 0);
  end

  // One full turn from IDLE; submit_after=0 means let ENTRY time out.
  task automatic do_turn(input int submit_after, input logic m, output int rv_n, output int en_n,
                         output int rs_n, output int nr_n, output logic cap, output logic sc,
                         output logic [7:0] tc);
    rv_n = 0; en_n = 0; rs_n = 0; nr_n = 0;
    bus.start_pulse = 1; @(negedge clk); bus.start_pulse = 0;
    for (int g = 0; g < 60 && bus.sel == 2'b11; g++) begin
      rv_n++;
      if (bus.new_rand) nr_n++;
      @(negedge clk);
    end
    for (int g = 0; g < 60 && bus.sel == 2'b01; g++) begin
      en_n++;
      if (en_n == submit_after) begin bus.submit_pulse = 1; bus.match = m; end
      @(negedge clk);
      bus.submit_pulse = 0;
    end
    cap = bus.capture_turn; sc = bus.score_inc; tc = bus.turn_count;
    for (int g = 0; g < 60 && bus.sel == 2'b10; g++) begin
      rs_n++;
      if (bus.new_rand) nr_n++;
      @(negedge clk);
    end
  endtask

  int         rv_n, en_n, rs_n, nr_n, n;
  logic       cap, sc;
  logic [7:0] tc;

  initial begin
    rst_n = 0;
    bus.start_pulse = 0; bus.submit_pulse = 0; bus.abort = 0; bus.peek_score = 0; bus.match = 0;
    repeat (3) @(negedge clk);
    check("reset_sel", bus.sel, 0);
    check("reset_busy", bus.busy, 0);
    rst_n = 1;

    // 1: reset asserted mid-REVEAL takes effect immediately
    bus.start_pulse = 1; @(negedge clk); bus.start_pulse = 0;
    @(negedge clk);
    check("t1_in_reveal", bus.sel, 3);
    #2 rst_n = 0;
    #1;
    check("t1_async_sel", bus.sel, 0);
    check("t1_async_busy", bus.busy, 0);
    check("t1_async_turns", bus.turn_count, 0);
    @(negedge clk); rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("t1_no_strobe", bus.new_rand, 0);
    end

    // 2: submit with match two cycles into ENTRY
    do_turn(2, 1'b1, rv_n, en_n, rs_n, nr_n, cap, sc, tc);
    check("t2_reveal_len", rv_n, RV);
    check("t2_new_rand_once", nr_n, 1);
    check("t2_entry_len", en_n, 2);
    check("t2_capture", cap, 1);
    check("t2_score", sc, 1);
    check("t2_turns", tc, 1);
    check("t2_result_len", rs_n, RC);
    check("t2_back_idle", bus.busy, 0);
    bus.abort = 1; @(negedge clk); bus.abort = 0;
    check("t2_abort_clear", bus.turn_count, 0);

    // 3: no submit -> timeout, no score
    do_turn(0, 1'b1, rv_n, en_n, rs_n, nr_n, cap, sc, tc);
    check("t3_entry_len", en_n, TO);
    check("t3_capture", cap, 1);
    check("t3_score", sc, 0);
    check("t3_turns", tc, 1);

    // 4: second turn ends the game; submit ignored; start restarts
    do_turn(1, 1'b0, rv_n, en_n, rs_n, nr_n, cap, sc, tc);
    check("t4_turns", tc, 2);
    check("t4_game_over", bus.game_over, 1);
    check("t4_sel", bus.sel, 0);
    bus.submit_pulse = 1; bus.match = 1; @(negedge clk); bus.submit_pulse = 0;
    check("t4_submit_ignored", bus.capture_turn, 0);
    check("t4_still_over", bus.game_over, 1);
    bus.start_pulse = 1; @(negedge clk); bus.start_pulse = 0;
    check("t4_restart_turns", bus.turn_count, 0);
    check("t4_restart_sel", bus.sel, 3);

    // 5: peek in ENTRY changes sel only
    for (int g = 0; g < 60 && bus.sel != 2'b01; g++) @(negedge clk);
    n = 1;
    bus.peek_score = 1;
    repeat (3) begin
      @(negedge clk); n++;
      check("t5_peek_sel", bus.sel, 0);
    end
    bus.peek_score = 0;
    @(negedge clk); n++;
    check("t5_unpeek_sel", bus.sel, 1);
    for (int g = 0; g < 60; g++) begin
      @(negedge clk);
      if (bus.sel != 2'b01) break;
      n++;
    end
    check("t5_entry_len", n, TO);
    check("t5_timeout_capture", bus.capture_turn, 1);
    for (int g = 0; g < 60 && bus.sel == 2'b10; g++) @(negedge clk);

    // 6: submit in REVEAL ignored, abort in RESULT, start+submit in IDLE
    bus.start_pulse = 1; @(negedge clk); bus.start_pulse = 0;
    bus.submit_pulse = 1; @(negedge clk); bus.submit_pulse = 0;
    check("t6_reveal_submit_sel", bus.sel, 3);
    check("t6_reveal_submit_cap", bus.capture_turn, 0);
    for (int g = 0; g < 60 && bus.sel != 2'b01; g++) @(negedge clk);
    bus.submit_pulse = 1; bus.match = 0; @(negedge clk); bus.submit_pulse = 0;
    check("t6_in_result", bus.sel, 2);
    bus.abort = 1; @(negedge clk); bus.abort = 0;
    check("t6_abort_sel", bus.sel, 0);
    check("t6_abort_turns", bus.turn_count, 0);
    check("t6_abort_busy", bus.busy, 0);
    bus.start_pulse = 1; bus.submit_pulse = 1; @(negedge clk);
    bus.start_pulse = 0; bus.submit_pulse = 0;
    check("t6_start_wins_sel", bus.sel, 3);
    check("t6_start_wins_rand", bus.new_rand, 1);
    check("t6_start_wins_cap", bus.capture_turn, 0);

    // Random phase, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start_pulse  = ($urandom_range(7) == 0);
      bus.submit_pulse = ($urandom_range(5) == 0);
      bus.abort        = ($urandom_range(63) == 0);
      bus.peek_score   = ($urandom_range(3) == 0);
      bus.match        = 1'($urandom_range(1));
    end
    @(negedge clk);
    bus.start_pulse = 0; bus.submit_pulse = 0; bus.abort = 0; bus.peek_score = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
